irq_ctrl: RTL and testbench

- Interrupt controller feeding the processor's program-counter register.
- Latches edge-triggered requests from NSRC peripheral sources, applies an enable mask and picks one winner by fixed priority (lowest index wins).
- Drives the single `irq` line into the PC, captures the return address (EPC) and winning source ID at acceptance, and holds off further requests until the handler executes return-from-interrupt.
- Sits between peripherals and the PC / kernel-mode logic.

---
 rtl/irq_ctrl.sv | 121 ++++++++++++
 tb/tb_irq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_ctrl.sv
// Edge-latched, masked interrupt controller driving irq into the PC; captures EPC/cause at acceptance.
// Optional macro IRQ_ROTATE_PRIO_EN selects round-robin arbitration instead of lowest-index priority.
module irq_ctrl #(
  parameter int              NSRC     = 8,
  parameter int              IDW      = $clog2(NSRC),
  parameter logic [NSRC-1:0] MASK_RST = '1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [31:0]     ia,
  input  logic [31:0]     pcin,
  input  logic            eret,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wd,
  output logic            irq,
  output logic [31:0]     epc,
  output logic [IDW-1:0]  cause,
  output logic            in_service,
  output logic [NSRC-1:0] pending
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t          state;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] hist;
  logic [NSRC-1:0] new_edge;
  logic [NSRC-1:0] req_vec;
  logic [NSRC-1:0] clr;
  logic [IDW-1:0]  winner;
  logic            accept;
  logic            unused_ia;

  assign unused_ia = ^ia[30:0];
  assign new_edge  = irq_src & ~hist;
  assign req_vec   = pending & mask;
  // Acceptance mirrors the PC's own vector-load condition.
  assign accept    = (state == REQ) && !ia[31];
  assign clr       = accept ? (NSRC'(1) << cause) : '0;

  function automatic logic [IDW-1:0] lowest(input logic [NSRC-1:0] v);
    lowest = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowest = IDW'(i);
    end
  endfunction

`ifdef IRQ_ROTATE_PRIO_EN
  logic [IDW-1:0]    ptr;
  logic [2*NSRC-1:0] dbl;
  logic [IDW:0]      sum;

  // Rotate the request vector so the pointer lands at bit 0, then undo the offset.
  always_comb begin
    dbl    = {req_vec, req_vec} >> ptr;
    sum    = {1'b0, lowest(dbl[NSRC-1:0])} + {1'b0, ptr};
    winner = (sum >= (IDW+1)'(NSRC)) ? IDW'(sum - (IDW+1)'(NSRC)) : IDW'(sum);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (cause == IDW'(NSRC - 1)) ? '0 : cause + 1'b1;
    end
  end
`else
  assign winner = lowest(req_vec);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      irq        <= 1'b0;
      in_service <= 1'b0;
      epc        <= '0;
      cause      <= '0;
      pending    <= '0;
      mask       <= MASK_RST;
      hist       <= '0;
    end else begin
      hist <= irq_src;
      if (mask_we) mask <= mask_wd;
      // A fresh edge on the source being cleared keeps its pending bit set.
      pending <= (pending & ~clr) | new_edge;
      case (state)
        IDLE: begin
          if (|req_vec) begin
            state <= REQ;
            irq   <= 1'b1;
            cause <= winner;
          end
        end
        REQ: begin
          if (!ia[31]) begin
            state      <= SERVICE;
            irq        <= 1'b0;
            in_service <= 1'b1;
            epc        <= pcin;
          end else if (!mask[cause]) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        SERVICE: begin
          if (eret) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          irq        <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: behavioural model compared every cycle, directed scenarios plus random traffic.
module tb_irq_ctrl;
  localparam int NSRC = 8;
  localparam int IDW  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NSRC-1:0] irq_src = '0;
  logic [31:0]     ia = '0;
  logic [31:0]     pcin = '0;
  logic            eret = 1'b0;
  logic            mask_we = 1'b0;
  logic [NSRC-1:0] mask_wd = '0;
  logic            irq;
  logic [31:0]     epc;
  logic [IDW-1:0]  cause;
  logic            in_service;
  logic [NSRC-1:0] pending;

  int n_chk  = 0;
  int n_fail = 0;

  irq_ctrl #(.NSRC(NSRC)) dut (
    .clk(clk), .reset(reset), .irq_src(irq_src), .ia(ia), .pcin(pcin),
    .eret(eret), .mask_we(mask_we), .mask_wd(mask_wd), .irq(irq),
    .epc(epc), .cause(cause), .in_service(in_service), .pending(pending)
  );

  always #5 clk = ~clk;

  // Behavioural model: phase 0 = idle, 1 = requesting, 2 = servicing.
  int              m_phase, m_cause, m_ptr;
  logic [31:0]     m_epc;
  logic [NSRC-1:0] m_pend, m_mask, m_hist;
  int              t_phase, t_cause, t_ptr, t_win;
  logic [31:0]     t_epc;
  logic [NSRC-1:0] t_edges, t_clr;

  function automatic int pick(input logic [NSRC-1:0] v, input int start);
    for (int k = 0; k < NSRC; k++) begin
      if (v[(start + k) % NSRC]) return (start + k) % NSRC;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_cause = 0; m_ptr = 0; m_epc = '0;
      m_pend = '0; m_mask = '1; m_hist = '0;
    end else begin
      t_edges = irq_src & ~m_hist;
      t_clr = '0;
      t_phase = m_phase; t_cause = m_cause; t_epc = m_epc; t_ptr = m_ptr;
      if (m_phase == 0) begin
        t_win = pick(m_pend & m_mask, m_ptr);
        if (t_win >= 0) begin t_phase = 1; t_cause = t_win; end
      end else if (m_phase == 1) begin
        if (!ia[31]) begin
          t_phase = 2; t_epc = pcin; t_clr[m_cause] = 1'b1;
`ifdef IRQ_ROTATE_PRIO_EN
          t_ptr = (m_cause + 1) % NSRC;
`endif
        end else if (!m_mask[m_cause]) begin
          t_phase = 0;
        end
      end else if (eret) begin
        t_phase = 0;
      end
      m_pend = (m_pend & ~t_clr) | t_edges;
      m_hist = irq_src;
      if (mask_we) m_mask = mask_wd;
      m_phase = t_phase; m_cause = t_cause; m_epc = t_epc; m_ptr = t_ptr;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("m_irq", irq, m_phase == 1);
      chk("m_in_service", in_service, m_phase == 2);
      chk("m_epc", epc, m_epc);
      chk("m_cause", cause, m_cause);
      chk("m_pending", pending, m_pend);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

`ifdef IRQ_ROTATE_PRIO_EN
  localparam int EXP_A = 5, EXP_B = 1;
`else
  localparam int EXP_A = 1, EXP_B = 5;
`endif

  initial begin
    #1 reset = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    chk("rst_irq", irq, 0); chk("rst_pend", pending, 0);
    chk("rst_epc", epc, 0); chk("rst_cause", cause, 0);
    chk("rst_insvc", in_service, 0);

    // Reset asserted while requesting.
    ia = 32'h8000_0000; irq_src = 8'h02; step();
    irq_src = '0; step();
    chk("pre_rst_irq", irq, 1);
    #2 reset = 1'b0;
    #1 chk("midrst_irq", irq, 0); chk("midrst_pend", pending, 0);
    chk("midrst_insvc", in_service, 0);
    step(); reset = 1'b1; step();

    // Single request on source 3.
    ia = 32'h0000_0040; pcin = 32'h0000_0044; irq_src = 8'h08; step();
    chk("single_pend", pending, 8'h08); chk("single_irq0", irq, 0);
    irq_src = '0; step();
    chk("single_irq1", irq, 1); chk("single_cause_req", cause, 3);
    step();
    chk("single_insvc", in_service, 1); chk("single_epc", epc, 32'h44);
    chk("single_cause", cause, 3); chk("single_pend_clr", pending, 0);
    eret = 1'b1; step(); eret = 1'b0;
    chk("single_eret", in_service, 0);

    // Kernel-space hold-off.
    ia = 32'h8000_0100; irq_src = 8'h10; step();
    irq_src = '0; step();
    chk("kern_irq", irq, 1);
    for (int i = 0; i < 5; i++) begin
      step(); chk("kern_hold", {irq, in_service}, 2'b10);
    end
    ia = 32'h0000_0200; pcin = 32'h0000_0204; step();
    chk("kern_accept", in_service, 1); chk("kern_epc", epc, 32'h204);
    eret = 1'b1; step(); eret = 1'b0;

    // Fixed/rotating priority.
    do_reset();
    ia = '0; irq_src = 8'h24; step();
    chk("prio_pend", pending, 8'h24);
    irq_src = '0; step();
    chk("prio_cause2", cause, 2); chk("prio_irq", irq, 1);
    step();
    chk("prio_svc2", in_service, 1); chk("prio_pend20", pending, 8'h20);
    irq_src = 8'h02; step();
    chk("prio_pend22", pending, 8'h22);
    irq_src = '0; eret = 1'b1; step(); eret = 1'b0;
    chk("prio_idle_gap", {irq, in_service}, 2'b00);
    step();
    chk("prio_causeA", cause, EXP_A); chk("prio_irqA", irq, 1);
    step(); eret = 1'b1; step(); eret = 1'b0; step();
    chk("prio_causeB", cause, EXP_B); chk("prio_irqB", irq, 1);
    step(); eret = 1'b1; step(); eret = 1'b0;

    // Mask gating.
    ia = 32'h8000_0000; mask_we = 1'b1; mask_wd = 8'hFB; step();
    mask_we = 1'b0; irq_src = 8'h04; step();
    chk("mask_pend", pending, 8'h04); chk("mask_irq0", irq, 0);
    irq_src = '0; step(); step();
    chk("mask_still0", irq, 0);
    mask_we = 1'b1; mask_wd = 8'hFF; step();
    mask_we = 1'b0; step();
    chk("mask_req", irq, 1); chk("mask_cause", cause, 2);
    mask_we = 1'b1; mask_wd = 8'hFB; step();
    mask_we = 1'b0; step();
    chk("mask_drop", irq, 0); chk("mask_keep", pending, 8'h04);
    mask_we = 1'b1; mask_wd = 8'hFF; step();
    mask_we = 1'b0; step();
    ia = '0; step();
    chk("mask_svc", in_service, 1);
    eret = 1'b1; step(); eret = 1'b0;

    // New edge colliding with acceptance of the same source.
    ia = 32'h8000_0000; irq_src = 8'h08; step();
    irq_src = '0; step();
    chk("coll_req", irq, 1);
    ia = '0; irq_src = 8'h08; step();
    chk("coll_svc", in_service, 1); chk("coll_pend", pending, 8'h08);
    irq_src = '0; eret = 1'b1; step(); eret = 1'b0; step();
    chk("coll_rereq", irq, 1); chk("coll_cause", cause, 3);
    step(); eret = 1'b1; step(); eret = 1'b0; step();
    eret = 1'b1; step(); eret = 1'b0;
    chk("eret_idle", {irq, in_service}, 2'b00);
    step();
    chk("eret_idle2", {irq, in_service}, 2'b00);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      irq_src = NSRC'($urandom);
      ia      = {($urandom_range(0, 2) == 0), 31'($urandom)};
      pcin    = $urandom;
      eret    = ($urandom_range(0, 5) == 0);
      mask_we = ($urandom_range(0, 15) == 0);
      mask_wd = NSRC'($urandom);
      if (c == 700) begin
        #3 reset = 1'b0;
        step();
        reset = 1'b1;
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
